// File: rtl/fpu_pkg.sv
// Shared types for the FPU request arbiter: opcodes, FSM states and tag-pipe entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpu_pkg;

  localparam int OP_W     = 3;
  // Tag entries are sized for the largest supported requester count (8).
  localparam int MAX_ID_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3
  } fpu_op_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    QUIESCED
  } arb_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Bundle of requester, FPU, response and quiesce signals around the FPU arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per requester; FPU and response paths have none.
// Modports: master = arbiter side, slave = requesters/FPU/power-controller side.
interface fpu_req_arbiter_if
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;

  logic                      fpu_valid_in;
  logic [OP_W-1:0]           fpu_operation;
  logic [DATA_W-1:0]         fpu_operand_a;
  logic [DATA_W-1:0]         fpu_operand_b;
  logic [DATA_W-1:0]         fpu_result;
  logic                      fpu_valid_out;
  logic                      fpu_exception;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_exception;

  logic                      quiesce_req;
  logic                      quiesce_ack;
  logic                      tag_error;

  modport master (
    input  req_valid, req_op, req_a, req_b,
    input  fpu_result, fpu_valid_out, fpu_exception,
    input  quiesce_req,
    output req_ready,
    output fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b,
    output rsp_valid, rsp_id, rsp_result, rsp_exception,
    output quiesce_ack, tag_error
  );

  modport slave (
    output req_valid, req_op, req_a, req_b,
    output fpu_result, fpu_valid_out, fpu_exception,
    output quiesce_req,
    input  req_ready,
    input  fpu_valid_in, fpu_operation, fpu_operand_a, fpu_operand_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_exception,
    input  quiesce_ack, tag_error
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or above i_ptr, wrapping to index 0.
// Latency: combinational.
// Backpressure: none; o_any=0 when no request is set.
// Ports: i_req request vector, i_ptr search start, o_gnt one-hot grant, o_idx encoded winner, o_any.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Two ascending passes: the upper segment [ptr, N) first, then the wrapped
  // segment [0, ptr). The first hit in that order is the winner.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (IDX_W'(j) >= i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_any && i_req[j] && (IDX_W'(j) < i_ptr)) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one pipelined FPU among NUM_REQ requesters (round-robin), tags each issue
//   with its requester ID and returns results with that ID; quiesce drains in-flight work.
// Latency: grant/issue combinational, response = FPU_LATENCY cycles after issue, no added regs.
// Backpressure: req_ready one-hot or zero; responses cannot be stalled.
// Ports: clk, rst_n (sync, active-low), bus (fpu_req_arbiter_if.master).
// Optional: FPU_ARB_PRIO_EN gives requester 0 strict priority over the round-robin.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int FPU_LATENCY = 2,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_req_arbiter_if.master bus
);

  localparam int OUT_W = $clog2(FPU_LATENCY + 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  tag_t               r_tag [FPU_LATENCY];
  logic [OUT_W-1:0]   r_outstanding;
  logic [OUT_W-1:0]   w_out_nxt;
  logic               r_tag_error;

  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [ID_W-1:0]    w_rr_idx;
  logic               w_rr_any;
  logic               w_prio;
  logic [NUM_REQ-1:0] w_win_gnt;
  logic [ID_W-1:0]    w_win_idx;
  logic               w_issue;
  logic [OP_W-1:0]    w_op;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  tag_t               w_tail;
  logic               w_id_bad;
  logic               w_set_err;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_rr_any)
  );

`ifdef FPU_ARB_PRIO_EN
  assign w_prio = bus.req_valid[0];
`else
  assign w_prio = 1'b0;
`endif

  assign w_win_gnt = w_prio ? NUM_REQ'(1) : w_rr_gnt;
  assign w_win_idx = w_prio ? '0 : w_rr_idx;
  // A priority hit implies w_rr_any, so the round-robin "any" covers both modes.
  assign w_issue   = (r_state == RUN) && w_rr_any;

  // Operand isolation: the FPU inputs stay at zero unless something is issued.
  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_issue && w_win_gnt[i]) begin
        w_op = bus.req_op[i*OP_W +: OP_W];
        w_a  = bus.req_a[i*DATA_W +: DATA_W];
        w_b  = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready     = w_issue ? w_win_gnt : '0;
  assign bus.fpu_valid_in  = w_issue;
  assign bus.fpu_operation = w_op;
  assign bus.fpu_operand_a = w_a;
  assign bus.fpu_operand_b = w_b;

  assign w_tail            = r_tag[FPU_LATENCY-1];
  assign bus.rsp_valid     = bus.fpu_valid_out;
  assign bus.rsp_id        = w_tail.id[ID_W-1:0];
  assign bus.rsp_result    = bus.fpu_result;
  assign bus.rsp_exception = bus.fpu_exception;
  assign bus.quiesce_ack   = (r_state == QUIESCED);
  assign bus.tag_error     = r_tag_error;

  // Tail valid and FPU valid must agree every cycle: either side alone is an
  // orphan result or a dropped one. An out-of-range ID is also a corrupted tag.
  assign w_id_bad  = w_tail.valid && (int'(w_tail.id) >= NUM_REQ);
  assign w_set_err = (bus.fpu_valid_out != w_tail.valid) || w_id_bad;

  always_comb begin
    w_out_nxt = r_outstanding;
    if (w_issue && !w_tail.valid) begin
      w_out_nxt = r_outstanding + 1'b1;
    end else if (!w_issue && w_tail.valid) begin
      w_out_nxt = r_outstanding - 1'b1;
    end
  end

  // DRAIN looks at the post-retire count so the last retiring result and the
  // move to QUIESCED happen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:      if (bus.quiesce_req) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!bus.quiesce_req)        w_state_nxt = RUN;
        else if (w_out_nxt == '0)    w_state_nxt = QUIESCED;
      end
      QUIESCED: if (!bus.quiesce_req) w_state_nxt = RUN;
      default:                       w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_rr_ptr      <= '0;
      r_outstanding <= '0;
      r_tag_error   <= 1'b0;
      for (int k = 0; k < FPU_LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      // Priority grants to requester 0 leave the rotation untouched.
      if (w_issue && !w_prio) begin
        r_rr_ptr <= (w_rr_idx == ID_W'(NUM_REQ-1)) ? '0 : w_rr_idx + 1'b1;
      end
      r_tag[0] <= '{valid: w_issue, id: MAX_ID_W'(w_win_idx)};
      for (int k = 1; k < FPU_LATENCY; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (w_set_err) begin
        r_tag_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with a two-stage behavioural FPU.
// Latency: n/a.
// Backpressure: n/a.
module tb_fpu_req_arbiter;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int e;

  fpu_req_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  fpu_req_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (32),
    .FPU_LATENCY (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2:0]  t_op [4];
  logic [31:0] t_a  [4];
  logic [31:0] t_b  [4];
  assign bus.req_op = {t_op[3], t_op[2], t_op[1], t_op[0]};
  assign bus.req_a  = {t_a[3], t_a[2], t_a[1], t_a[0]};
  assign bus.req_b  = {t_b[3], t_b[2], t_b[1], t_b[0]};

  // Behavioural FPU: fixed 2-cycle pipe, reset together with the arbiter.
  function automatic logic [31:0] fpu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    return a ^ b ^ {29'd0, op};
  endfunction

  logic        m_v1, m_v2, m_exc2, inj_vld;
  logic [2:0]  m_op1;
  logic [31:0] m_a1, m_b1, m_res2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_op1 <= '0; m_a1 <= '0; m_b1 <= '0;
      m_res2 <= '0; m_exc2 <= 1'b0;
    end else begin
      m_v1   <= bus.fpu_valid_in;
      m_op1  <= bus.fpu_operation;
      m_a1   <= bus.fpu_operand_a;
      m_b1   <= bus.fpu_operand_b;
      m_v2   <= m_v1;
      m_res2 <= fpu_f(m_op1, m_a1, m_b1);
      m_exc2 <= (m_op1 == 3'd3) && (m_b1 == 32'd0);
    end
  end

  assign bus.fpu_valid_out = m_v2 | inj_vld;
  assign bus.fpu_result    = m_res2;
  assign bus.fpu_exception = m_exc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.quiesce_req = 1'b0;
    inj_vld         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    mid();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_fpu_valid_in", 32'(bus.fpu_valid_in), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_quiesce_ack", 32'(bus.quiesce_ack), 32'h0);
    chk("rst_tag_error", 32'(bus.tag_error), 32'h0);

    // All four requesters valid: rotation 0,1,2,3,0 and responses two cycles later
    next_cyc();
    rst_n = 1'b1;
    t_op[0] = 3'd0; t_a[0] = 32'h11111111; t_b[0] = 32'h0000000F;
    t_op[1] = 3'd1; t_a[1] = 32'h22222222; t_b[1] = 32'h000000F0;
    t_op[2] = 3'd2; t_a[2] = 32'h33333333; t_b[2] = 32'h00000F00;
    t_op[3] = 3'd3; t_a[3] = 32'h44444444; t_b[3] = 32'h0000F000;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      mid();
      if (k < 5) begin
`ifdef FPU_ARB_PRIO_EN
        e = 0;
`else
        e = k % 4;
`endif
        chk("rr_req_ready", 32'(bus.req_ready), 32'(4'b0001 << e));
        chk("rr_fpu_valid_in", 32'(bus.fpu_valid_in), 32'h1);
        chk("rr_operand_a", bus.fpu_operand_a, t_a[e]);
      end else begin
        chk("rr_idle_valid_in", 32'(bus.fpu_valid_in), 32'h0);
      end
      if (k < 2 || k == 7) begin
        chk("rr_rsp_idle", 32'(bus.rsp_valid), 32'h0);
      end else begin
`ifdef FPU_ARB_PRIO_EN
        e = 0;
`else
        e = (k - 2) % 4;
`endif
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("rr_rsp_id", 32'(bus.rsp_id), 32'(e));
        chk("rr_rsp_result", bus.rsp_result, fpu_f(t_op[e], t_a[e], t_b[e]));
      end
      next_cyc();
      if (k == 4) bus.req_valid = '0;
    end

    // Single requester 2 ADD 1.0 + 2.0, then requester 1 DIV by zero
    t_op[2] = 3'd0; t_a[2] = 32'h3F800000; t_b[2] = 32'h40000000;
    bus.req_valid = 4'b0100;
    mid();
    chk("add_req_ready", 32'(bus.req_ready), 32'h4);
    chk("add_valid_in", 32'(bus.fpu_valid_in), 32'h1);
    chk("add_operation", 32'(bus.fpu_operation), 32'h0);
    chk("add_operand_a", bus.fpu_operand_a, 32'h3F800000);
    chk("add_operand_b", bus.fpu_operand_b, 32'h40000000);
    next_cyc();
    t_op[1] = 3'd3; t_a[1] = 32'h12345678; t_b[1] = 32'h0;
    bus.req_valid = 4'b0010;
    mid();
    chk("div_req_ready", 32'(bus.req_ready), 32'h2);
    next_cyc();
    bus.req_valid = '0;
    mid();
    chk("iso_valid_in", 32'(bus.fpu_valid_in), 32'h0);
    chk("iso_operand_a", bus.fpu_operand_a, 32'h0);
    chk("iso_operation", 32'(bus.fpu_operation), 32'h0);
    chk("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("add_rsp_id", 32'(bus.rsp_id), 32'h2);
    chk("add_rsp_result", bus.rsp_result, 32'h7F800000);
    chk("add_rsp_exc", 32'(bus.rsp_exception), 32'h0);
    next_cyc();
    mid();
    chk("div_rsp_id", 32'(bus.rsp_id), 32'h1);
    chk("div_rsp_result", bus.rsp_result, 32'h1234567B);
    chk("div_rsp_exc", 32'(bus.rsp_exception), 32'h1);
    next_cyc();
    mid();
    chk("div_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // Quiesce: issue Q0 and Q1, request quiesce in Q1, ack in Q4
    next_cyc();
    bus.req_valid = 4'b0001;
    mid();
    chk("q0_req_ready", 32'(bus.req_ready), 32'h1);
    next_cyc();
    bus.quiesce_req = 1'b1;
    mid();
    chk("q1_still_issues", 32'(bus.req_ready), 32'h1);
    chk("q1_ack", 32'(bus.quiesce_ack), 32'h0);
    next_cyc();
    mid();
    chk("q2_no_grant", 32'(bus.req_ready), 32'h0);
    chk("q2_no_issue", 32'(bus.fpu_valid_in), 32'h0);
    chk("q2_ack", 32'(bus.quiesce_ack), 32'h0);
    chk("q2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("q2_rsp_id", 32'(bus.rsp_id), 32'h0);
    next_cyc();
    mid();
    chk("q3_ack", 32'(bus.quiesce_ack), 32'h0);
    chk("q3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    next_cyc();
    mid();
    chk("q4_ack", 32'(bus.quiesce_ack), 32'h1);
    chk("q4_no_grant", 32'(bus.req_ready), 32'h0);
    next_cyc();
    bus.quiesce_req = 1'b0;
    mid();
    chk("q5_ack_hold", 32'(bus.quiesce_ack), 32'h1);
    chk("q5_no_grant", 32'(bus.req_ready), 32'h0);
    next_cyc();
    mid();
    chk("q6_resume", 32'(bus.req_ready), 32'h1);
    chk("q6_ack_low", 32'(bus.quiesce_ack), 32'h0);
    next_cyc();
    bus.req_valid = '0;

    // Orphan FPU result sets the sticky tag error
    repeat (3) next_cyc();
    inj_vld = 1'b1;
    mid();
    chk("orphan_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("orphan_err_before", 32'(bus.tag_error), 32'h0);
    next_cyc();
    inj_vld = 1'b0;
    mid();
    chk("orphan_err_set", 32'(bus.tag_error), 32'h1);
    next_cyc();
    mid();
    chk("orphan_err_sticky", 32'(bus.tag_error), 32'h1);

    // Reset one cycle after an issue from requester 1
    next_cyc();
    bus.req_valid = 4'b0010;
    mid();
    chk("r0_req_ready", 32'(bus.req_ready), 32'h2);
    next_cyc();
    bus.req_valid = '0;
    rst_n = 1'b0;
    mid();
    chk("r1_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    next_cyc();
    mid();
    chk("r2_no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("r2_err_cleared", 32'(bus.tag_error), 32'h0);
    next_cyc();
    rst_n = 1'b1;
    bus.quiesce_req = 1'b1;
    mid();
    chk("r3_no_stale_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("r3_ack", 32'(bus.quiesce_ack), 32'h0);
    next_cyc();
    mid();
    chk("r4_ack", 32'(bus.quiesce_ack), 32'h0);
    next_cyc();
    mid();
    chk("r5_ack_zero_outstanding", 32'(bus.quiesce_ack), 32'h1);
    next_cyc();
    bus.quiesce_req = 1'b0;
    next_cyc();
    bus.req_valid = 4'hF;
    mid();
    chk("r7_ptr_reset", 32'(bus.req_ready), 32'h1);

    // Requesters 0 and 1 valid continuously
    next_cyc();
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      mid();
`ifdef FPU_ARB_PRIO_EN
      chk("pair_grant", 32'(bus.req_ready), 32'h1);
`else
      chk("pair_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
`endif
      next_cyc();
    end
    bus.req_valid = 4'b0010;
    mid();
    chk("pair_req1_alone", 32'(bus.req_ready), 32'h2);
    next_cyc();
    bus.req_valid = '0;
    repeat (4) next_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_req_arbiter.md
Name: fpu_req_arbiter

Overview:
Shares one pipelined fpu instance between NUM_REQ requesters using round-robin arbitration with a valid/ready request handshake. Tracks the ID of every in-flight operation in a tag pipeline matched to the FPU latency, and steers each result back with its requester ID. Provides a quiesce handshake so the power controller can idle the FPU only after all in-flight work has drained.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width (EXPONENT_WIDTH+MANTISSA_WIDTH+1 of the fpu)
FPU_LATENCY, 2, cycles from fpu valid_in to valid_out (fixed, no backpressure)
ID_W, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_op  in  NUM_REQ*3  flattened operation codes, requester i at [3i+:3]
req_a  in  NUM_REQ*DATA_W  flattened operand A
req_b  in  NUM_REQ*DATA_W  flattened operand B
fpu_valid_in  out  1  issue strobe to fpu
fpu_operation  out  3  issued opcode
fpu_operand_a  out  DATA_W  issued operand A
fpu_operand_b  out  DATA_W  issued operand B
fpu_result  in  DATA_W  fpu result
fpu_valid_out  in  1  fpu result valid
fpu_exception  in  1  fpu exception flag
rsp_valid  out  1  response valid (no backpressure; requesters must accept)
rsp_id  out  ID_W  owner of the response
rsp_result  out  DATA_W  result passthrough
rsp_exception  out  1  exception passthrough
quiesce_req  in  1  level request to stop issuing and drain
quiesce_ack  out  1  high while quiesced (zero in flight)
tag_error  out  1  sticky: fpu_valid_out with no matching in-flight tag

Behaviour:
- Reset (sync, rst_n=0 at posedge): state=RUN, rr_ptr=0, tag pipe all invalid, outstanding=0, tag_error=0. In-flight results are discarded. Combinational outputs follow from the cleared state: req_ready=0 (until req_valid seen), fpu_valid_in=0, rsp_valid=0, quiesce_ack=0.
- FSM states: RUN, DRAIN, QUIESCED.
  - RUN: grants enabled. quiesce_req=1 -> DRAIN. The sampling cycle still issues.
  - DRAIN: no grants. When outstanding==0 -> QUIESCED.
  - QUIESCED: no grants; quiesce_ack=1. quiesce_req=0 -> RUN.
  - quiesce_req deasserted while in DRAIN -> RUN.
- Arbitration is combinational within the cycle. Winner = first i with req_valid[i], searching from rr_ptr upward with wrap. In RUN only: req_ready[winner]=1 and fpu_valid_in=1, with op and operands muxed from the winner. Otherwise all zero, and fpu_operation/fpu_operand_a/fpu_operand_b are driven to 0 (operand isolation).
- On issue: rr_ptr <= (winner+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Throughput is one issue per cycle. Issue-to-rsp latency is FPU_LATENCY cycles; the arbiter adds no registers on the response path.
- Tag pipe: FPU_LATENCY-entry shift register of {valid, id}, advancing every cycle. The head loads {fpu_valid_in, winner}.
  - rsp_valid=fpu_valid_out, rsp_id=tail.id, rsp_result=fpu_result, rsp_exception=fpu_exception.
  - fpu_valid_out while tail.valid=0 sets tag_error. tag_error clears only on reset.
  - tail.valid with fpu_valid_out=0 is a dropped result and also sets tag_error.
- outstanding = count of valid tag entries, width $clog2(FPU_LATENCY+1). Issue and retire in the same cycle leave it unchanged.
- Requests are not required to be held. A requester that drops req_valid before being granted loses nothing.

Optional Feature:
FPU_ARB_PRIO_EN
- Defined: requester 0 has strict priority. If req_valid[0] is set in RUN, it wins regardless of rr_ptr, and rr_ptr is not updated on its grant. Other requesters arbitrate round-robin as usual.
- Undefined: pure round-robin for all requesters.

Decomposition:
- Package fpu_pkg: fpu_op_e enum (ADD=0, SUB=1, MUL=2, DIV=3); arb_state_e {RUN, DRAIN, QUIESCED}; tag_t struct {valid, id}.
- One sub-module, rr_arbiter (req vector + ptr -> one-hot grant + encoded index), which is reusable elsewhere.
- Tag pipe and FSM stay inline.

Test Plan:
- All 4 requesters valid continuously, rr_ptr=0 after reset -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3 starts 2 cycles after the first grant.
- Only req 2 valid, op=ADD, a=0x3F800000, b=0x40000000 -> req_ready[2]=1 that cycle; fpu_valid_in=1 with op=0; 2 cycles later rsp_valid=1, rsp_id=2, result matches the fpu model.
- Issue on cycles 0 and 1, quiesce_req=1 on cycle 1 -> cycle 1 still issues; state goes to DRAIN; quiesce_ack=1 on cycle 4; no req_ready while quiesce_req remains high.
- Inject fpu_valid_out=1 with no prior issue -> tag_error=1 next cycle and stays set; reset clears it.
- Assert rst_n=0 one cycle after an issue -> rsp_valid with a stale id never appears; outstanding=0; rr_ptr=0.
- With FPU_ARB_PRIO_EN defined and reqs 0 and 1 both valid continuously -> req 0 granted every cycle; req 1 never granted until req 0 drops.
